// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared state encodings and FP latency default for the stall controller
package pipe_stall_ctrl_pkg;

    // Registered pipeline decision; also read by the FP unit and the debug unit.
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_LSTALL = 2'b01,
        ST_FWAIT  = 2'b10,
        ST_HALT   = 2'b11
    } state_t;

    // Cycles from FP issue into EX until the FP result can be forwarded.
    localparam int FP_LAT_DEF = 3;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter used for the stall/flush performance counters
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset, clears q
//   inc   count enable for this cycle
//   q     count value, sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - turns hazard requests into per-stage enable/flush controls
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   load_stall, branch_taken        load-use stall request, taken-branch flush request
//   fp_issue, fp_dep                FP op in ID, ID depends on the in-flight FP result
//   halt                            debug freeze of the whole pipeline
//   pc_en, ifid_en, ifid_flush      PC / IF/ID controls
//   idex_en, idex_flush             ID/EX controls
//   exmem_en, memwb_en              EX/MEM, MEM/WB enables
//   valid_id..valid_wb              per-stage real-instruction flags
//   state                           registered decision (RUN/LSTALL/FWAIT/HALT)
//   stall_cnt, flush_cnt            saturating performance counters
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int FP_LAT = FP_LAT_DEF,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_stall,
    input  logic             branch_taken,
    input  logic             fp_issue,
    input  logic             fp_dep,
    input  logic             halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             valid_id,
    output logic             valid_ex,
    output logic             valid_mem,
    output logic             valid_wb,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [3:0] FP_LAT4 = 4'(FP_LAT);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] fp_cnt;
    logic       fp_hz;
    logic       stall_inc;
    logic       flush_inc;
    logic       fp_load;

    assign fp_hz = fp_dep && (fp_cnt != 4'd0);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; a taken branch returns to RUN because the
    // stalled ID instruction is on the wrong path anyway.
    always_comb begin
        state_d = ST_RUN;
        if (halt) begin
            state_d = ST_HALT;
        end else if (branch_taken) begin
            state_d = ST_RUN;
        end else if (fp_hz) begin
            state_d = ST_FWAIT;
        end else if (load_stall) begin
            state_d = ST_LSTALL;
        end
    end

    // Output decode. Flush is raised alongside enable where both apply;
    // the pipeline register gives flush priority.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (!rstn || halt) begin
            // everything frozen
        end else if (branch_taken) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            flush_inc  = 1'b1;
        end else if (fp_hz || load_stall) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            stall_inc  = 1'b1;
        end else begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
        end
    end

    assign state = state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_id  <= 1'b0;
            valid_ex  <= 1'b0;
            valid_mem <= 1'b0;
            valid_wb  <= 1'b0;
        end else begin
            if (ifid_flush) begin
                valid_id <= 1'b0;
            end else if (ifid_en) begin
                valid_id <= 1'b1;
            end
            if (idex_flush) begin
                valid_ex <= 1'b0;
            end else if (idex_en) begin
                valid_ex <= valid_id;
            end
            if (exmem_en) begin
                valid_mem <= valid_ex;
            end
            if (memwb_en) begin
                valid_wb <= valid_mem;
            end
        end
    end

    // FP result occupancy: reload on a real FP op entering EX, otherwise
    // count down to zero unless frozen.
    assign fp_load = fp_issue && valid_id && idex_en && !idex_flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fp_cnt <= 4'd0;
        end else if (fp_load) begin
            fp_cnt <= FP_LAT4;
        end else if (!halt && (fp_cnt != 4'd0)) begin
            fp_cnt <= fp_cnt - 4'd1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (stall_inc),
        .q    (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (flush_inc),
        .q    (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl against a behavioural model
module tb_pipe_stall_ctrl;

    localparam int FP_LAT = 3;
    localparam int CNT_W  = 32;
    localparam int SMALL_W = 3;

    logic clk = 1'b0;
    logic rstn;
    logic load_stall, branch_taken, fp_issue, fp_dep, halt;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic valid_id, valid_ex, valid_mem, valid_wb;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en, s_memwb_en;
    logic s_valid_id, s_valid_ex, s_valid_mem, s_valid_wb;
    logic [1:0] s_state;
    logic [SMALL_W-1:0] s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.FP_LAT(FP_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .load_stall(load_stall), .branch_taken(branch_taken),
        .fp_issue(fp_issue), .fp_dep(fp_dep), .halt(halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .valid_id(valid_id), .valid_ex(valid_ex), .valid_mem(valid_mem), .valid_wb(valid_wb),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stall_ctrl #(.FP_LAT(FP_LAT), .CNT_W(SMALL_W)) dut_small (
        .clk(clk), .rstn(rstn), .load_stall(load_stall), .branch_taken(branch_taken),
        .fp_issue(fp_issue), .fp_dep(fp_dep), .halt(halt),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
        .idex_flush(s_idex_flush), .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
        .valid_id(s_valid_id), .valid_ex(s_valid_ex), .valid_mem(s_valid_mem), .valid_wb(s_valid_wb),
        .state(s_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: pipeline occupancy as plain flags, FP occupancy as an integer.
    localparam int M_RUN = 0, M_LSTALL = 1, M_FWAIT = 2, M_HALT = 3, M_BRANCH = 4;
    bit     m_vid, m_vex, m_vmem, m_vwb;
    int     m_fp, m_st;
    longint m_stall, m_flush;

    task automatic model_reset();
        m_vid = 0; m_vex = 0; m_vmem = 0; m_vwb = 0;
        m_fp = 0; m_st = 0; m_stall = 0; m_flush = 0;
    endtask

    function automatic int mode_now();
        if (halt) return M_HALT;
        if (branch_taken) return M_BRANCH;
        if (fp_dep && m_fp > 0) return M_FWAIT;
        if (load_stall) return M_LSTALL;
        return M_RUN;
    endfunction

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
    function automatic logic [6:0] ctrl_of(input int mode);
        case (mode)
            M_HALT:   return 7'b000_0000;
            M_BRANCH: return 7'b111_1111;
            M_FWAIT,
            M_LSTALL: return 7'b000_1111;
            default:  return 7'b110_1011;
        endcase
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint lim = (longint'(1) << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // One clock: compare everything at the negedge, advance the model, return just after posedge.
    task automatic step();
        int mode;
        @(negedge clk);
        mode = mode_now();
        check_eq("ctrl", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en},
                 ctrl_of(mode));
        check_eq("valid", {valid_wb, valid_mem, valid_ex, valid_id}, {m_vwb, m_vmem, m_vex, m_vid});
        check_eq("state", state, m_st);
        check_eq("stall_cnt", stall_cnt, m_stall);
        check_eq("flush_cnt", flush_cnt, m_flush);
        check_eq("small_stall_cnt", s_stall_cnt, sat(m_stall, SMALL_W));
        if (mode != M_HALT) begin
            if (mode == M_RUN && fp_issue && m_vid) m_fp = FP_LAT;
            else if (m_fp > 0) m_fp = m_fp - 1;
            m_vwb = m_vmem;
            m_vmem = m_vex;
            m_vex = (mode == M_RUN) ? m_vid : 1'b0;
            if (mode == M_RUN) m_vid = 1;
            else if (mode == M_BRANCH) m_vid = 0;
        end
        if (mode == M_FWAIT || mode == M_LSTALL) m_stall++;
        if (mode == M_BRANCH) m_flush++;
        m_st = (mode == M_BRANCH) ? M_RUN : mode;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ls, input logic br, input logic fi, input logic fd, input logic h);
        load_stall = ls; branch_taken = br; fp_issue = fi; fp_dep = fd; halt = h;
    endtask

    initial begin
        rstn = 1'b0;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        #2;
        check_eq("reset_ctrl", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}, 7'd0);
        check_eq("reset_valid", {valid_wb, valid_mem, valid_ex, valid_id}, 4'd0);
        check_eq("reset_state", state, 2'b00);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Idle: valid bits fill one stage per cycle.
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq("fill_valid", {valid_wb, valid_mem, valid_ex, valid_id}, (64'd1 << i) - 1);
        end

        // Single-cycle load-use stall.
        set_in(1, 0, 0, 0, 0);
        step();
        check_eq("ls_valid_ex", valid_ex, 1'b0);
        check_eq("ls_state", state, 2'b01);
        check_eq("ls_stall_cnt", stall_cnt, 1);

        // FP issue, one independent instruction, then a held dependency: FP_LAT-1 stalls.
        set_in(0, 0, 1, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 1, 0);
        for (int i = 0; i < FP_LAT - 1; i++) begin
            step();
            check_eq("fp_state", state, 2'b10);
        end
        step();
        check_eq("fp_resume_state", state, 2'b00);
        check_eq("fp_stall_cnt", stall_cnt, FP_LAT);

        // Branch overrides a simultaneous load stall.
        set_in(1, 1, 0, 0, 0);
        step();
        check_eq("br_stall_cnt", stall_cnt, FP_LAT);
        check_eq("br_flush_cnt", flush_cnt, 1);
        check_eq("br_valid_id_ex", {valid_ex, valid_id}, 2'b00);
        check_eq("br_state", state, 2'b00);

        // Halt in the middle of an FP wait, then finish the remaining stall.
        set_in(0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 1, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 1, 0);
        step();
        check_eq("pre_halt_state", state, 2'b10);
        set_in(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("halt_state", state, 2'b11);
            check_eq("halt_stall_cnt", stall_cnt, FP_LAT + 1);
        end
        set_in(0, 0, 0, 1, 0);
        step();
        check_eq("post_halt_state", state, 2'b10);
        check_eq("post_halt_stall_cnt", stall_cnt, FP_LAT + 2);
        step();
        check_eq("post_halt_resume", state, 2'b00);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            set_in(($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
                   ($urandom_range(0, 11) == 0));
            step();
        end

        // Asynchronous reset in the middle of a stall.
        set_in(1, 0, 0, 0, 0);
        step();
        #2;
        rstn = 1'b0;
        #1;
        check_eq("arst_ctrl", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}, 7'd0);
        check_eq("arst_valid", {valid_wb, valid_mem, valid_ex, valid_id}, 4'd0);
        check_eq("arst_state", state, 2'b00);
        check_eq("arst_cnts", {stall_cnt, flush_cnt}, 64'd0);
        model_reset();
        set_in(0, 0, 0, 0, 0);
        rstn = 1'b1;
        step();
        check_eq("post_rst_state", state, 2'b00);

        // Saturation on the narrow-counter instance.
        set_in(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step();
        check_eq("sat_small", s_stall_cnt, 3'b111);
        check_eq("sat_wide", stall_cnt, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
